// File: rtl/ps2_quad_mouse_if.sv
// ----------------------------------------------------------------------------
// ps2_quad_mouse_if
// Bundles the data-side signals of the PS/2-to-retro-mouse converter so the
// host glue (hps_io side plus machine port read mux) and the converter share
// one port.
//
//   ps2_mouse  [24:0] packet word from hps_io (toggle strobe in bit 24)
//   quad_mode         0 = AMX handshake replay, 1 = free-running quadrature
//   scale      [1:0]  delta left-shift 0..3
//   sel               host read strobe, falling edge acknowledges (AMX mode)
//   dout       [6:0]  {M,L,R} buttons, Y pair, X pair
//   busy              either accumulator still holds motion
//
// master: drives the host-side inputs and observes dout/busy.
// slave : the converter itself.
// ----------------------------------------------------------------------------
interface ps2_quad_mouse_if;
    logic [24:0] ps2_mouse;
    logic        quad_mode;
    logic [1:0]  scale;
    logic        sel;
    logic [6:0]  dout;
    logic        busy;

    modport master (
        output ps2_mouse,
        output quad_mode,
        output scale,
        output sel,
        input  dout,
        input  busy
    );

    modport slave (
        input  ps2_mouse,
        input  quad_mode,
        input  scale,
        input  sel,
        output dout,
        output busy
    );
endinterface

// File: rtl/ps2_quad_mouse.sv
// ----------------------------------------------------------------------------
// ps2_quad_mouse
// Converts MiSTer ps2_mouse packets into retro mouse port signals.  Each axis
// accumulates the signed packet deltas (scaled, saturated, overflowed axes
// dropped) and replays the motion one STEP at a time, either as AMX-style
// direction pairs acknowledged by the host read strobe, or as free-running
// Gray-code quadrature phases.
//
// Parameters
//   ACC_W     accumulator width per axis, signed (>= 10)
//   STEP      accumulator units consumed per emitted step
//   RATE_DIV  clk_sys cycles between quadrature steps (>= 2)
//   BTN_LOW   1 = button bits on dout are active-low
//
// Ports
//   clk_sys   system clock
//   reset     asynchronous, active-high reset
//   bus       ps2_quad_mouse_if.slave (ps2_mouse, quad_mode, scale, sel in;
//             dout, busy out)
// ----------------------------------------------------------------------------
module ps2_quad_mouse #(
    parameter int ACC_W    = 12,
    parameter int STEP     = 4,
    parameter int RATE_DIV = 64,
    parameter bit BTN_LOW  = 1'b0
) (
    input  logic              clk_sys,
    input  logic              reset,
    ps2_quad_mouse_if.slave   bus
);

    // Sum width: a 9-bit delta shifted by up to 3 plus an ACC_W accumulator
    // never overflows ACC_W+4 bits, so saturation can be decided exactly.
    localparam int SW    = ACC_W + 4;
    localparam int DIV_W = $clog2(RATE_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RATE_DIV - 1);

    localparam logic signed [SW-1:0] POS_LIM = {{(SW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SW-1:0] NEG_LIM = -POS_LIM;

    // Symmetric clamp: the most-negative code is never produced.
    localparam logic signed [ACC_W-1:0] POS_LIM_A = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] NEG_LIM_A = {1'b1, {(ACC_W-2){1'b0}}, 1'b1};

    localparam logic signed [ACC_W-1:0] STEP_A  = ACC_W'(STEP);
    localparam logic signed [ACC_W-1:0] NSTEP_A = -STEP_A;

    // ------------------------------------------------------------------
    // Shared control: edge detectors, quadrature divider, buttons, busy
    // ------------------------------------------------------------------
    logic             strobe_reg;
    logic             sel_reg;
    logic             mode_reg;
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] div_next;
    logic [2:0]       btn_reg;
    logic             busy_reg;

    logic             packet;
    logic             sel_fall;
    logic             mode_edge;
    logic             tick;

    logic [3:0]       pair_bus;
    logic [1:0]       nz_next;

    // Bit 3 of the packet word carries no information for this converter.
    logic             unused_ps2_bit3;
    assign unused_ps2_bit3 = bus.ps2_mouse[3];

    assign packet    = bus.ps2_mouse[24] ^ strobe_reg;
    assign sel_fall  = sel_reg & ~bus.sel;
    assign mode_edge = bus.quad_mode ^ mode_reg;
    assign tick      = bus.quad_mode & ~mode_edge & (div_reg == DIV_LAST);

    // Divider only runs in quadrature mode and restarts on every mode switch,
    // so the first tick always lands RATE_DIV cycles after entering the mode.
    always_comb begin
        div_next = div_reg;
        if (mode_edge || !bus.quad_mode) begin
            div_next = '0;
        end else if (div_reg == DIV_LAST) begin
            div_next = '0;
        end else begin
            div_next = div_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            strobe_reg <= 1'b0;
            sel_reg    <= 1'b0;
            mode_reg   <= 1'b0;
            div_reg    <= '0;
            btn_reg    <= {3{BTN_LOW}};
            busy_reg   <= 1'b0;
        end else begin
            strobe_reg <= bus.ps2_mouse[24];
            sel_reg    <= bus.sel;
            mode_reg   <= bus.quad_mode;
            div_reg    <= div_next;
            // Port order is {M,L,R}; packet order is {M,R,L}.
            btn_reg    <= {bus.ps2_mouse[2], bus.ps2_mouse[0], bus.ps2_mouse[1]} ^ {3{BTN_LOW}};
            busy_reg   <= |nz_next;
        end
    end

    assign bus.dout = {btn_reg, pair_bus};
    assign bus.busy = busy_reg;

    // ------------------------------------------------------------------
    // Per-axis datapath: gi = 0 is X (packet bits 15:8), gi = 1 is Y (23:16)
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_axis
        // AMX direction code for a positive accumulator: X right = 01,
        // Y up = 10.  The negative code is the complement.
        localparam logic [1:0] AMX_POS = (gi == 0) ? 2'b01 : 2'b10;
        localparam logic [1:0] AMX_NEG = ~AMX_POS;

        logic signed [ACC_W-1:0] acc_reg;
        logic signed [ACC_W-1:0] acc_next;
        logic [1:0]              pair_reg;
        logic [1:0]              pair_next;

        logic [7:0]              mag;
        logic                    sgn;
        logic                    ovf;
        logic signed [SW-1:0]    delta_w;
        logic signed [SW-1:0]    acc_w;
        logic signed [SW-1:0]    sum_w;
        logic signed [ACC_W-1:0] sat_v;
        logic signed [ACC_W-1:0] step_v;
        logic                    nz;
        logic                    pos;

        assign mag = bus.ps2_mouse[8 + 8*gi +: 8];
        assign sgn = bus.ps2_mouse[4 + gi];
        assign ovf = bus.ps2_mouse[6 + gi];
        assign nz  = (acc_reg != '0);
        assign pos = ~acc_reg[ACC_W-1];

        // Decode, scale and saturate the incoming delta; also precompute
        // the accumulator after one step toward zero.
        always_comb begin
            delta_w = '0;
            if (!ovf) begin
                delta_w = {{(SW-9){sgn}}, sgn, mag} <<< bus.scale;
            end
            acc_w = {{(SW-ACC_W){acc_reg[ACC_W-1]}}, acc_reg};
            sum_w = acc_w + delta_w;

            if (sum_w > POS_LIM) begin
                sat_v = POS_LIM_A;
            end else if (sum_w < NEG_LIM) begin
                sat_v = NEG_LIM_A;
            end else begin
                sat_v = sum_w[ACC_W-1:0];
            end

            // A remainder smaller than one step is dropped rather than
            // overshooting past zero.
            if (acc_reg > STEP_A) begin
                step_v = acc_reg - STEP_A;
            end else if (acc_reg < NSTEP_A) begin
                step_v = acc_reg + STEP_A;
            end else begin
                step_v = '0;
            end
        end

        always_comb begin
            acc_next  = acc_reg;
            pair_next = pair_reg;
            if (mode_edge) begin
                acc_next  = '0;
                pair_next = 2'b00;
            end else begin
                if (packet) begin
                    acc_next = sat_v;
                end
                if (!bus.quad_mode) begin
                    // The acknowledge beats a pending step; the step is
                    // retried once the pair reads 00.
                    if (sel_fall) begin
                        pair_next = 2'b00;
                    end else if (!packet && pair_reg == 2'b00 && nz) begin
                        acc_next  = step_v;
                        pair_next = pos ? AMX_POS : AMX_NEG;
                    end
                end else if (tick && !packet && nz) begin
                    acc_next  = step_v;
                    // Forward Gray walk 00->01->11->10, reverse otherwise.
                    pair_next = pos ? {pair_reg[0], ~pair_reg[1]}
                                    : {~pair_reg[0], pair_reg[1]};
                end
            end
        end

        always_ff @(posedge clk_sys or posedge reset) begin
            if (reset) begin
                acc_reg  <= '0;
                pair_reg <= 2'b00;
            end else begin
                acc_reg  <= acc_next;
                pair_reg <= pair_next;
            end
        end

        assign pair_bus[2*gi +: 2] = pair_reg;
        assign nz_next[gi]         = (acc_next != '0);
    end

endmodule
